// File: rtl/antilog_pkg.sv
// Shared constants and stage record types for the antilog pipeline.
package antilog_pkg;

  localparam int I_BW     = 8;
  localparam int O_BW     = 32;
  localparam int MAX_CODE = 32;
  localparam int SHIFT_BW = $clog2(O_BW);

  localparam logic [O_BW-1:0] SAT_VALUE = 32'hFFFF_FFFF;

  // First stage: raw code plus pre-computed range flags so the decoder
  // only has to pick between zero, a shifted one, and the saturation value.
  typedef struct packed {
    logic [I_BW-1:0] code;
    logic            is_zero;
    logic            is_over;
    logic            last;
  } s1_t;

  // Output stage: everything the downstream interface sees.
  typedef struct packed {
    logic [O_BW-1:0] value;
    logic            sat;
    logic            last;
  } s2_t;

  // Codes above MAX_CODE have no power-of-two meaning and saturate.
  function automatic logic code_is_over(input logic [I_BW-1:0] code);
    return code > I_BW'(MAX_CODE);
  endfunction

endpackage

// File: rtl/antilog_dec.sv
// Combinational log-code decoder: leading-ones place -> power of two.
module antilog_dec
  import antilog_pkg::*;
(
  input  logic [I_BW-1:0] code,
  input  logic            is_zero,
  input  logic            is_over,
  output logic [O_BW-1:0] value,
  output logic            sat
);

  logic [SHIFT_BW-1:0] shamt;

  // Code k in 1..MAX_CODE places the single set bit at position k-1.
  assign shamt = SHIFT_BW'(code - I_BW'(1));

  // Select saturation, zero, or the shifted one for the current code.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    value = '0;
    sat   = 1'b0;
    if (is_over) begin
      value = SAT_VALUE;
      sat   = 1'b1;
    end else if (!is_zero) begin
      value = {{(O_BW-1){1'b0}}, 1'b1} << shamt;
    end
  end

endmodule

// File: rtl/antilog.sv
// Two-stage ready/valid pipeline turning a leading-ones place back into
// the largest power of two it represents.
module antilog
  import antilog_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            ready_o,
  output logic [O_BW-1:0] data_o,
  output logic            sat_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_i
);

  s1_t             s1_q;
  logic            s1_valid_q;
  s2_t             s2_q;
  logic            s2_valid_q;

  logic            s2_free;
  logic            s1_adv;
  logic            in_xfer;
  logic [O_BW-1:0] dec_value;
  logic            dec_sat;

  // S2 can take a new beat when empty or when its current beat leaves now.
  assign s2_free = !s2_valid_q || ready_i;
  assign s1_adv  = s1_valid_q && s2_free;
  // Depends on ready_i but never on valid_i, so no combinational loop upstream.
  assign ready_o = en_i && (!s1_valid_q || s1_adv);
  assign in_xfer = valid_i && ready_o;

  antilog_dec u_dec (
    .code    (s1_q.code),
    .is_zero (s1_q.is_zero),
    .is_over (s1_q.is_over),
    .value   (dec_value),
    .sat     (dec_sat)
  );

  // S1: capture the code with its range flags and frame marker.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous and also clears the payload, not only valid,
    // so no stale sat/last can leak out after release.
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_xfer) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      s1_valid_q <= 1'b1;
      s1_q       <= '{code:    data_i,
                      is_zero: (data_i == '0),
                      is_over: code_is_over(data_i),
                      last:    last_i};
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: output register holding the decoded beat until downstream takes it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      s2_q       <= '{value: dec_value, sat: dec_sat, last: s1_q.last};
    end else if (ready_i) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign data_o  = s2_q.value;
  assign sat_o   = s2_q.sat;
  assign last_o  = s2_q.last;
  assign valid_o = s2_valid_q;

endmodule

// File: tb/tb_antilog.sv
// Self-checking bench for antilog: scripted scenarios and randomized
// traffic scored against a transaction-level reference model.
module tb_antilog;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        sat_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;

  antilog dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .sat_o   (sat_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] code;
    logic       last;
    int         acc;
  } beat_t;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  string       cur_test   = "";

  beat_t       inflight[$];
  logic [7:0]  stim_code[$];
  logic        stim_last[$];
  bit          ready_plan[$];
  bit          en_plan[$];
  logic [31:0] got_data[$];
  logic        got_sat[$];
  logic        got_last[$];

  // Reference decode: {sat, value} from the code by plain arithmetic.
  function automatic logic [32:0] ref_antilog(input int code);
    longint p;
    if (code == 0) return 33'd0;
    if (code > 32) return {1'b1, 32'hFFFF_FFFF};
    p = 1;
    for (int i = 1; i < code; i++) p = p * 2;
    return {1'b0, p[31:0]};
  endfunction

  // Reference log: number of binary digits of v (0 for v = 0).
  function automatic int ref_log(input longint v);
    int k = 0;
    while (v > 0) begin
      v = v / 2;
      k++;
    end
    return k;
  endfunction

  function automatic longint floor_pow2(input longint v);
    longint p = 1;
    if (v == 0) return 0;
    while (p * 2 <= v) p = p * 2;
    return p;
  endfunction

  task automatic clear_stim();
    stim_code.delete();
    stim_last.delete();
    ready_plan.delete();
    en_plan.delete();
    got_data.delete();
    got_sat.delete();
    got_last.delete();
  endtask

  // Drive stim_code/stim_last through the DUT, checking every cycle against
  // the model. Entered and left one time unit after a rising edge.
  task automatic run_stream(input int valid_pct, input int ready_pct,
                            input int en_pct, input int budget);
    int          idx = 0;
    int          n   = stim_code.size();
    int          c   = 0;
    bit          exp_ready, exp_valid, prev_hold;
    logic [32:0] exp_word;
    logic [31:0] prev_data;
    logic        prev_sat, prev_last;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_sat  = 1'b0;
    prev_last = 1'b0;
    while ((idx < n || inflight.size() > 0) && c < budget) begin
      en_i    = (en_plan.size() > 0)    ? en_plan.pop_front()    : ($urandom_range(99) < en_pct);
      ready_i = (ready_plan.size() > 0) ? ready_plan.pop_front() : ($urandom_range(99) < ready_pct);
      if (idx < n && $urandom_range(99) < valid_pct) begin
        valid_i = 1'b1;
        data_i  = stim_code[idx];
        last_i  = stim_last[idx];
      end else begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        last_i  = 1'($urandom);
      end
      #2;
      exp_ready = en_i && (inflight.size() < 2 || ready_i);
      exp_valid = inflight.size() > 0 && cyc >= inflight[0].acc + 2;
      vectors++;
      if (ready_o !== exp_ready) begin
        miscompares++;
        $display("FAIL %s ready_o cyc %0d: got %b expected %b", cur_test, cyc, ready_o, exp_ready);
      end
      vectors++;
      if (valid_o !== exp_valid) begin
        miscompares++;
        $display("FAIL %s valid_o cyc %0d: got %b expected %b", cur_test, cyc, valid_o, exp_valid);
      end
      if (exp_valid) begin
        exp_word = ref_antilog(int'(inflight[0].code));
        vectors++;
        if (data_o !== exp_word[31:0]) begin
          miscompares++;
          $display("FAIL %s data_o code %0d: got %h expected %h", cur_test, inflight[0].code, data_o, exp_word[31:0]);
        end
        vectors++;
        if (sat_o !== exp_word[32]) begin
          miscompares++;
          $display("FAIL %s sat_o code %0d: got %b expected %b", cur_test, inflight[0].code, sat_o, exp_word[32]);
        end
        vectors++;
        if (last_o !== inflight[0].last) begin
          miscompares++;
          $display("FAIL %s last_o: got %b expected %b", cur_test, last_o, inflight[0].last);
        end
      end
      if (prev_hold) begin
        vectors++;
        if ({valid_o, data_o, sat_o, last_o} !== {1'b1, prev_data, prev_sat, prev_last}) begin
          miscompares++;
          $display("FAIL %s stall_hold: got %b/%h/%b/%b expected 1/%h/%b/%b", cur_test,
                   valid_o, data_o, sat_o, last_o, prev_data, prev_sat, prev_last);
        end
      end
      prev_hold = exp_valid && !ready_i;
      prev_data = data_o;
      prev_sat  = sat_o;
      prev_last = last_o;
      if (exp_valid && ready_i) begin
        got_data.push_back(data_o);
        got_sat.push_back(sat_o);
        got_last.push_back(last_o);
        void'(inflight.pop_front());
      end
      if (valid_i && exp_ready) begin
        inflight.push_back('{code: stim_code[idx], last: stim_last[idx], acc: cyc});
        idx++;
      end
      cyc++;
      c++;
      @(posedge clk_i);
      #1;
    end
    vectors++;
    if (c >= budget) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d of %0d beats delivered", cur_test, got_data.size(), n);
      inflight.delete();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n_i = 1'b0;
    en_i    = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'd255;
    last_i  = 1'b1;
    ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({valid_o, data_o, sat_o, last_o} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got %b/%h/%b/%b expected 0/00000000/0/0", valid_o, data_o, sat_o, last_o);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset ready_en1: got %b expected 1", ready_o);
    end
    en_i = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ready_en0: got %b expected 0", ready_o);
    end
    rst_n_i = 1'b1;
    en_i    = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_codes();
    logic [31:0] exp_vals[5];
    logic [7:0]  codes[5];
    exp_vals = '{32'h0, 32'h1, 32'h2, 32'h0001_0000, 32'h8000_0000};
    codes    = '{8'd0, 8'd1, 8'd2, 8'd17, 8'd32};
    cur_test = "codes";
    clear_stim();
    foreach (codes[i]) begin
      stim_code.push_back(codes[i]);
      stim_last.push_back(i == 4);
    end
    run_stream(100, 100, 100, 40);
    vectors++;
    if (got_data.size() != 5) begin
      miscompares++;
      $display("FAIL codes count: got %0d expected 5", got_data.size());
    end else begin
      foreach (exp_vals[i]) begin
        vectors++;
        if (got_data[i] !== exp_vals[i] || got_sat[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL codes beat%0d: got %h sat %b expected %h sat 0", i, got_data[i], got_sat[i], exp_vals[i]);
        end
      end
    end
    cur_test = "saturate";
    clear_stim();
    stim_code.push_back(8'd33);
    stim_last.push_back(1'b0);
    stim_code.push_back(8'd255);
    stim_last.push_back(1'b1);
    run_stream(100, 100, 100, 40);
    vectors++;
    if (got_data.size() != 2) begin
      miscompares++;
      $display("FAIL saturate count: got %0d expected 2", got_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_data[i] !== 32'hFFFF_FFFF || got_sat[i] !== 1'b1) begin
          miscompares++;
          $display("FAIL saturate beat%0d: got %h sat %b expected ffffffff sat 1", i, got_data[i], got_sat[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    cur_test = "backpressure";
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      stim_code.push_back(8'($urandom_range(1, 32)));
      stim_last.push_back(i == 3);
    end
    // Ready for the two fill cycles, then low for three once output appears.
    ready_plan = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_stream(100, 100, 100, 60);
    vectors++;
    if (got_last.size() != 4) begin
      miscompares++;
      $display("FAIL backpressure count: got %0d expected 4", got_last.size());
    end else begin
      vectors++;
      if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001) begin
        miscompares++;
        $display("FAIL backpressure last_flags: got %b%b%b%b expected 0001",
                 got_last[0], got_last[1], got_last[2], got_last[3]);
      end
    end
  endtask

  task automatic test_enable();
    cur_test = "enable";
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      stim_code.push_back(8'($urandom_range(0, 40)));
      stim_last.push_back(i == 3);
    end
    en_plan = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stream(100, 100, 100, 60);
    vectors++;
    if (got_data.size() != 4) begin
      miscompares++;
      $display("FAIL enable count: got %0d expected 4", got_data.size());
    end
  endtask

  task automatic test_mid_reset();
    cur_test = "mid_reset";
    en_i    = 1'b1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'd255;
    last_i  = 1'b1;
    @(posedge clk_i);
    #1;
    data_i = 8'd5;
    last_i = 1'b0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b1 || sat_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset pre: got valid %b sat %b expected valid 1 sat 1", valid_o, sat_o);
    end
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    vectors++;
    if ({valid_o, data_o, sat_o, last_o} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset cleared: got %b/%h/%b/%b expected 0/00000000/0/0", valid_o, data_o, sat_o, last_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      vectors++;
      if (valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset stale cyc %0d: got valid %b expected 0", i, valid_o);
      end
    end
    inflight.delete();
  endtask

  task automatic test_round_trip();
    longint vals[$];
    longint v;
    cur_test = "round_trip";
    clear_stim();
    vals = '{64'd0, 64'd1, 64'd3, 64'hFFFF_FFFF, 64'h8000_0000};
    for (int i = 0; i < 35; i++) begin
      v = longint'($urandom) >> $urandom_range(0, 31);
      vals.push_back(v);
    end
    foreach (vals[i]) begin
      stim_code.push_back(8'(ref_log(vals[i])));
      stim_last.push_back(1'($urandom));
    end
    run_stream(80, 80, 100, 400);
    vectors++;
    if (got_data.size() != vals.size()) begin
      miscompares++;
      $display("FAIL round_trip count: got %0d expected %0d", got_data.size(), vals.size());
    end else begin
      foreach (vals[i]) begin
        v = floor_pow2(vals[i]);
        vectors++;
        if (got_data[i] !== v[31:0] || got_sat[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL round_trip v=%h: got %h sat %b expected %h sat 0", vals[i], got_data[i], got_sat[i], v[31:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    cur_test = "random";
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      stim_code.push_back(($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40)));
      stim_last.push_back($urandom_range(3) == 0);
    end
    run_stream(70, 60, 80, 5000);
    vectors++;
    if (got_data.size() != 300) begin
      miscompares++;
      $display("FAIL random count: got %0d expected 300", got_data.size());
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    test_reset();
    test_codes();
    test_backpressure();
    test_enable();
    test_mid_reset();
    test_round_trip();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/antilog.md
ANTILOG -- requirements
Module: antilog

Interface
REQ-001 I_BW, 8, input log-code width (localparam, fixed).
REQ-002 O_BW, 32, output linear-value width (localparam, fixed).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, synchronous and active-low.
REQ-005 en_i  input  1  block enable; low blocks new acceptances, in-flight data still drains.
REQ-006 data_i  input  I_BW  log code (leading-ones place, 0..32 valid; 33..255 out of range).
REQ-007 valid_i  input  1  input beat valid.
REQ-008 last_i  input  1  last beat of frame, travels with its beat.
REQ-009 ready_o  output  1  block accepts beat this cycle.
REQ-010 data_o  output  O_BW  reconstructed linear value.
REQ-011 sat_o  output  1  beat on data_o came from an out-of-range code.
REQ-012 valid_o  output  1  output beat valid.
REQ-013 last_o  output  1  last flag aligned with data_o.
REQ-014 ready_i  input  1  downstream accepts output beat.

Function
REQ-015 Input transfer when valid_i & ready_o; output transfer when valid_o & ready_i.
REQ-016 Mapping: code 0 -> 0; code k in 1..32 -> 1 << (k-1); code >= 33 -> 32'hFFFF_FFFF with sat_o=1; sat_o=0 otherwise.
REQ-017 Two register stages: S1 latches code, range flags, last; S2 (output register) latches decoded value, sat, last; data_o/sat_o/last_o/valid_o driven directly from S2.
REQ-018 Latency: beat accepted at edge N appears on outputs after edge N+2 when no backpressure.
REQ-019 S2 loads from S1 when S1 valid and (S2 empty or ready_i); S2 clears valid when drained with S1 empty.
REQ-020 S1 loads when input transfer occurs; S1 clears valid when it advances to S2 with no new transfer.
REQ-021 ready_o = en_i & (S1 empty | S1 advancing this cycle); combinational from ready_i allowed, from valid_i not allowed.
REQ-022 Full pipe with ready_i low: ready_o=0, S1 and S2 hold data, valid, last, sat unchanged.
REQ-023 Simultaneous output drain and input accept on full pipe: zero bubbles, one beat/cycle sustained.
REQ-024 valid_o, once asserted, stays high with stable data_o/sat_o/last_o until transferred.
REQ-025 en_i deassert mid-frame: no new beats accepted; beats already in S1/S2 complete normally.
REQ-026 Beat order and last_i-to-beat association preserved exactly; no beats dropped or duplicated.
REQ-027 Decode is the inverse of the log block's leading-ones place: antilog(log(v)) = largest power of two <= v.

Reset
REQ-028 While rst_n_i low at an edge: S1/S2 valid, data, sat, last cleared to 0.
REQ-029 Outputs after reset: data_o=0, sat_o=0, valid_o=0, last_o=0; ready_o = en_i.
REQ-030 Reset mid-frame discards all in-flight beats; no partial output after release.

Structure
REQ-031 Shared package holds I_BW, O_BW, MAX_CODE=32 and saturation value 32'hFFFF_FFFF.
REQ-032 One sub-module, antilog_dec: combinational code -> {value, sat} decoder, instantiated between S1 and S2.

Verification
REQ-033 Codes 0,1,2,17,32 back-to-back, ready_i=1 -> 0,1,2,0x0001_0000,0x8000_0000 from edge N+2, one per cycle, sat_o=0.
REQ-034 Codes 33 and 255 -> 0xFFFF_FFFF with sat_o=1 both.
REQ-035 4-beat frame (last on beat 4), ready_i low 3 cycles after first output -> ready_o low on full pipe, outputs stable, all 4 delivered in order, last_o on beat 4 only.
REQ-036 en_i dropped after beat 2 of 4 -> beats 1-2 emerge, ready_o=0 until en_i returns, beats 3-4 follow.
REQ-037 rst_n_i low one cycle with 2 beats in flight -> valid_o=0 next cycle, no stale beat afterward.
REQ-038 Round trip: random 32b v through log then antilog -> output equals largest power of two <= v (0 for v=0).
